// File: rtl/deserializador_tupla16_pkg.sv
// Shared definitions for the framed serial-to-parallel front end.
// Holds the FSM state encoding, the default word width and the
// width of the good-frame counter.
package deserializador_tupla16_pkg;

    localparam int unsigned ANCHO_DEF = 16;
    localparam int unsigned CONTEO_W  = 8;

    // Fixed 2-bit state encoding shared by the design and its users.
    typedef enum logic [1:0] {
        S_REPOSO   = 2'd0,
        S_DESPLAZA = 2'd1,
        S_PARIDAD  = 2'd2,
        S_EMITE    = 2'd3
    } estado_t;

    // Bit counter width able to hold the value ancho.
    function automatic int unsigned cuenta_w(input int unsigned ancho);
        return $clog2(ancho + 1);
    endfunction

endpackage

// File: rtl/deserializador_tupla16_if.sv
// Bus between the serial source and the deserializer.
//   Inicio/BitSerie/BitValido : framing strobe, serial bit, bit qualifier
//   Tupla/Habilitar           : assembled word and its one-cycle load pulse
//   Error/Ocupado/TramasOk    : reject pulse, frame-in-progress, good-frame count
interface deserializador_tupla16_if
    import deserializador_tupla16_pkg::*;
#(
    parameter int unsigned ANCHO = ANCHO_DEF
);
    logic                Inicio;
    logic                BitSerie;
    logic                BitValido;
    logic [ANCHO-1:0]    Tupla;
    logic                Habilitar;
    logic                Error;
    logic                Ocupado;
    logic [CONTEO_W-1:0] TramasOk;

    modport master (
        output Inicio, BitSerie, BitValido,
        input  Tupla, Habilitar, Error, Ocupado, TramasOk
    );

    modport slave (
        input  Inicio, BitSerie, BitValido,
        output Tupla, Habilitar, Error, Ocupado, TramasOk
    );
endinterface

// File: rtl/deserializador_tupla16_contador_bits.sv
// Up-counter with synchronous clear (priority) and enable.
//   clk_i/rst_i : clock, asynchronous active-high reset
//   clr_i/en_i  : clear to zero, increment by one
//   cuenta_o    : current count
module deserializador_tupla16_contador_bits #(
    parameter int unsigned W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cuenta_o
);
    logic [W-1:0] cuenta_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cuenta_q <= '0;
        end else if (clr_i) begin
            cuenta_q <= '0;
        end else if (en_i) begin
            cuenta_q <= cuenta_q + W'(1);
        end
    end

    assign cuenta_o = cuenta_q;
endmodule

// File: rtl/deserializador_tupla16.sv
// Assembles an ANCHO-bit word from a framed serial stream, optionally
// checks a trailing even-parity bit, and drives a downstream register.
//   Reloj/Reiniciar : clock, asynchronous active-high reset
//   bus (slave)     : Inicio/BitSerie/BitValido in; Tupla, Habilitar,
//                     Error, Ocupado, TramasOk out
module deserializador_tupla16
    import deserializador_tupla16_pkg::*;
#(
    parameter int unsigned ANCHO       = ANCHO_DEF,
    parameter bit          MSB_PRIMERO = 1'b1,
    parameter bit          PARIDAD     = 1'b1
) (
    input  logic                   Reloj,
    input  logic                   Reiniciar,
    deserializador_tupla16_if.slave bus
);
    localparam int unsigned        CNT_W  = cuenta_w(ANCHO);
    localparam logic [CNT_W-1:0]   ULTIMO = CNT_W'(ANCHO - 1);

    estado_t             estado_q;
    logic [ANCHO-1:0]    despl_q;
    logic [ANCHO-1:0]    despl_d;
    logic [ANCHO-1:0]    tupla_q;
    logic                hab_q;
    logic                err_q;
    logic [CONTEO_W-1:0] tramas_q;

    logic [CNT_W-1:0]    cuenta;
    logic                cnt_clr_c;
    logic                cnt_en_c;
    logic                ultimo_c;
    logic                paridad_ok_c;

    // Shift register with the incoming bit inserted at the configured end.
    always_comb begin
        despl_d = despl_q;
        if (MSB_PRIMERO) begin
            despl_d = {despl_q[ANCHO-2:0], bus.BitSerie};
        end else begin
            despl_d = {bus.BitSerie, despl_q[ANCHO-1:1]};
        end
    end

    // Inicio restarts the count in every state; a bit sampled together
    // with Inicio never counts.
    assign cnt_clr_c    = bus.Inicio;
    assign cnt_en_c     = (estado_q == S_DESPLAZA) && bus.BitValido && !bus.Inicio;
    assign ultimo_c     = (cuenta == ULTIMO);
    assign paridad_ok_c = ~((^despl_q) ^ bus.BitSerie);

    deserializador_tupla16_contador_bits #(
        .W (CNT_W)
    ) u_contador_bits (
        .clk_i    (Reloj),
        .rst_i    (Reiniciar),
        .clr_i    (cnt_clr_c),
        .en_i     (cnt_en_c),
        .cuenta_o (cuenta)
    );

    // Frame FSM. The word is loaded and Habilitar raised on the edge that
    // enters EMITE, so both are visible during the EMITE cycle itself.
    always_ff @(posedge Reloj or posedge Reiniciar) begin
        if (Reiniciar) begin
            estado_q <= S_REPOSO;
            despl_q  <= '0;
            tupla_q  <= '0;
            hab_q    <= 1'b0;
            err_q    <= 1'b0;
            tramas_q <= '0;
        end else begin
            hab_q <= 1'b0;
            err_q <= 1'b0;
            case (estado_q)
                S_REPOSO: begin
                    if (bus.Inicio) begin
                        despl_q  <= '0;
                        estado_q <= S_DESPLAZA;
                    end
                end
                S_DESPLAZA: begin
                    if (bus.Inicio) begin
                        despl_q <= '0;
                        err_q   <= 1'b1;
                    end else if (bus.BitValido) begin
                        despl_q <= despl_d;
                        if (ultimo_c) begin
                            if (PARIDAD) begin
                                estado_q <= S_PARIDAD;
                            end else begin
                                estado_q <= S_EMITE;
                                tupla_q  <= despl_d;
                                hab_q    <= 1'b1;
                                tramas_q <= tramas_q + CONTEO_W'(1);
                            end
                        end
                    end
                end
                S_PARIDAD: begin
                    if (bus.Inicio) begin
                        despl_q  <= '0;
                        err_q    <= 1'b1;
                        estado_q <= S_DESPLAZA;
                    end else if (bus.BitValido) begin
                        if (paridad_ok_c) begin
                            estado_q <= S_EMITE;
                            tupla_q  <= despl_q;
                            hab_q    <= 1'b1;
                            tramas_q <= tramas_q + CONTEO_W'(1);
                        end else begin
                            err_q    <= 1'b1;
                            estado_q <= S_REPOSO;
                        end
                    end
                end
                S_EMITE: begin
                    if (bus.Inicio) begin
                        despl_q  <= '0;
                        estado_q <= S_DESPLAZA;
                    end else begin
                        estado_q <= S_REPOSO;
                    end
                end
                default: estado_q <= S_REPOSO;
            endcase
        end
    end

    assign bus.Tupla     = tupla_q;
    assign bus.Habilitar = hab_q;
    assign bus.Error     = err_q;
    assign bus.TramasOk  = tramas_q;
    // Decoded straight from the state register.
    assign bus.Ocupado   = (estado_q != S_REPOSO);
endmodule

// File: tb/tb_deserializador_tupla16.sv
// Scoreboard bench: one MSB-first and one LSB-first instance share the
// same serial stimulus; expected words come from a frame-level model.
module tb_deserializador_tupla16;
    import deserializador_tupla16_pkg::*;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] tupla;
        logic [7:0]   tramas;
    } esperado_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inicio = 1'b0;
    logic bser = 1'b0;
    logic bval = 1'b0;

    always #5 clk = ~clk;

    deserializador_tupla16_if #(.ANCHO(W)) bus_m ();
    deserializador_tupla16_if #(.ANCHO(W)) bus_l ();

    assign bus_m.Inicio    = inicio;
    assign bus_m.BitSerie  = bser;
    assign bus_m.BitValido = bval;
    assign bus_l.Inicio    = inicio;
    assign bus_l.BitSerie  = bser;
    assign bus_l.BitValido = bval;

    deserializador_tupla16 #(.ANCHO(W), .MSB_PRIMERO(1'b1), .PARIDAD(1'b1)) u_msb (
        .Reloj     (clk),
        .Reiniciar (rst),
        .bus       (bus_m.slave)
    );

    deserializador_tupla16 #(.ANCHO(W), .MSB_PRIMERO(1'b0), .PARIDAD(1'b1)) u_lsb (
        .Reloj     (clk),
        .Reiniciar (rst),
        .bus       (bus_l.slave)
    );

    esperado_t q_m[$];
    esperado_t q_l[$];
    int checks = 0;
    int errors = 0;
    int exp_err = 0;
    int exp_hab = 0;
    int err_m = 0;
    int err_l = 0;
    int hab_m = 0;
    int hab_l = 0;
    int tramas_mod = 0;
    logic [W-1:0] prev_m = '0;
    logic [W-1:0] prev_l = '0;
    bit last_good = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] invertir(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < int'(W); i++) r[i] = x[W-1-i];
        return r;
    endfunction

    // Monitors: pop the scoreboard on every load pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_m.Habilitar || bus_m.Error)
                cmp("err_hab_m", 32'(bus_m.Habilitar & bus_m.Error), 32'd0);
            if (bus_m.Error) err_m++;
            if (bus_m.Habilitar) begin
                esperado_t e;
                hab_m++;
                cmp("pending_m", 32'(q_m.size() > 0), 32'd1);
                if (q_m.size() > 0) begin
                    e = q_m.pop_front();
                    cmp("tupla_m", 32'(bus_m.Tupla), 32'(e.tupla));
                    cmp("tramas_m", 32'(bus_m.TramasOk), 32'(e.tramas));
                end
            end else begin
                cmp("tupla_hold_m", 32'(bus_m.Tupla), 32'(prev_m));
            end
            prev_m = bus_m.Tupla;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_l.Habilitar || bus_l.Error)
                cmp("err_hab_l", 32'(bus_l.Habilitar & bus_l.Error), 32'd0);
            if (bus_l.Error) err_l++;
            if (bus_l.Habilitar) begin
                esperado_t e;
                hab_l++;
                cmp("pending_l", 32'(q_l.size() > 0), 32'd1);
                if (q_l.size() > 0) begin
                    e = q_l.pop_front();
                    cmp("tupla_l", 32'(bus_l.Tupla), 32'(e.tupla));
                    cmp("tramas_l", 32'(bus_l.TramasOk), 32'(e.tramas));
                end
            end else begin
                cmp("tupla_hold_l", 32'(bus_l.Tupla), 32'(prev_l));
            end
            prev_l = bus_l.Tupla;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bval = 1'($urandom_range(0, 1));
            bser = 1'($urandom_range(0, 1));
            step();
        end
        bval = 1'b0;
    endtask

    task automatic pulse_inicio();
        inicio = 1'b1;
        bval   = 1'($urandom_range(0, 1));
        bser   = 1'($urandom_range(0, 1));
        step();
        inicio = 1'b0;
        bval   = 1'b0;
        cmp("ocupado_inicio", 32'(bus_m.Ocupado), 32'd1);
    endtask

    // gap < 0 picks a random 0..3 idle cycles before each bit.
    task automatic send_bit(input logic b, input int gap);
        int g;
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        for (int i = 0; i < g; i++) begin
            bval = 1'b0;
            bser = 1'($urandom_range(0, 1));
            step();
        end
        bval = 1'b1;
        bser = b;
        step();
        bval = 1'b0;
    endtask

    // Whole frame: Inicio, data bits first-to-last as d[W-1]..d[0], parity.
    task automatic frame(input logic [W-1:0] d, input logic par, input int gap);
        bit good;
        pulse_inicio();
        for (int i = W - 1; i >= 0; i--) send_bit(d[i], gap);
        good = (((^d) ^ par) == 1'b0);
        if (good) begin
            tramas_mod = (tramas_mod + 1) % 256;
            q_m.push_back('{tupla: d, tramas: 8'(tramas_mod)});
            q_l.push_back('{tupla: invertir(d), tramas: 8'(tramas_mod)});
            exp_hab++;
        end else begin
            exp_err++;
        end
        send_bit(par, gap);
        cmp("ocupado_fin", 32'(bus_m.Ocupado), 32'(good));
        last_good = good;
    endtask

    task automatic partial(input int k);
        pulse_inicio();
        for (int i = 0; i < k; i++) send_bit(1'($urandom_range(0, 1)), -1);
        exp_err++;
    endtask

    task automatic check_zero(input string nm);
        cmp({nm, "_tupla_m"}, 32'(bus_m.Tupla), 32'd0);
        cmp({nm, "_hab_m"}, 32'(bus_m.Habilitar), 32'd0);
        cmp({nm, "_err_m"}, 32'(bus_m.Error), 32'd0);
        cmp({nm, "_ocup_m"}, 32'(bus_m.Ocupado), 32'd0);
        cmp({nm, "_tramas_m"}, 32'(bus_m.TramasOk), 32'd0);
        cmp({nm, "_tupla_l"}, 32'(bus_l.Tupla), 32'd0);
        cmp({nm, "_ocup_l"}, 32'(bus_l.Ocupado), 32'd0);
        cmp({nm, "_tramas_l"}, 32'(bus_l.TramasOk), 32'd0);
    endtask

    task automatic random_good(input int gap);
        logic [W-1:0] d;
        d = W'($urandom);
        frame(d, ^d, gap);
    endtask

    initial begin
        logic [W-1:0] d;
        logic p;
        int kind;

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        step();

        // Good frame, then the same frame with a bad parity bit.
        frame(16'hA5C3, 1'b0, 0);
        idle(1);
        cmp("ocupado_idle", 32'(bus_m.Ocupado), 32'd0);
        idle(1);
        frame(16'hA5C3, 1'b1, 0);
        idle(2);

        // Abort after 7 bits, restart with 0x0001.
        partial(7);
        frame(16'h0001, 1'b1, 0);
        idle(2);

        // Three-cycle gaps before every bit.
        frame(16'h0001, 1'b1, 3);
        idle(2);

        // Back-to-back frames, Inicio in the EMITE cycle.
        frame(16'h1234, ^16'h1234, 0);
        frame(16'hFFFE, ^16'hFFFE, -1);
        idle(2);

        // Reset mid-frame after 9 bits.
        pulse_inicio();
        for (int i = 0; i < 9; i++) send_bit(1'($urandom_range(0, 1)), 0);
        #1 rst = 1'b1;
        #1 check_zero("midrst");
        prev_m = '0;
        prev_l = '0;
        tramas_mod = 0;
        #1 rst = 1'b0;
        step();

        // 256 good frames wrap the counter back to zero.
        for (int n = 0; n < 256; n++) begin
            random_good(($urandom_range(0, 3) == 0) ? -1 : 0);
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        cmp("tramas_wrap_m", 32'(bus_m.TramasOk), 32'd0);
        cmp("tramas_wrap_l", 32'(bus_l.TramasOk), 32'd0);
        idle(2);

        // Mixed random traffic: good, bad parity, aborts (incl. in parity state).
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 3));
            if (kind == 2) partial(int'($urandom_range(0, 16)));
            d = W'($urandom);
            p = (kind == 1) ? ~(^d) : ^d;
            frame(d, p, -1);
            if ($urandom_range(0, 1) == 1) begin
                idle(1);
                if (last_good) cmp("ocupado_after", 32'(bus_m.Ocupado), 32'd0);
            end
        end
        idle(3);

        cmp("left_m", 32'(q_m.size()), 32'd0);
        cmp("left_l", 32'(q_l.size()), 32'd0);
        cmp("errcount_m", 32'(err_m), 32'(exp_err));
        cmp("errcount_l", 32'(err_l), 32'(exp_err));
        cmp("habcount_m", 32'(hab_m), 32'(exp_hab));
        cmp("habcount_l", 32'(hab_l), 32'(exp_hab));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/deserializador_tupla16.md
Name: deserializador_tupla16

Overview:
Serial-to-parallel front end that assembles a 16-bit word ("tupla") from a framed bit stream. It drives the data input and enable of the downstream 16-bit register (Registro16Bit). On a good frame it presents the assembled word and pulses the register's enable for exactly one cycle. Frames with a bad parity bit or an early restart are rejected and flagged.

Parameters:
ANCHO, 16, data bits per frame (downstream register width).
MSB_PRIMERO, 1, 1 = first received bit lands in Tupla[ANCHO-1]; 0 = first bit lands in Tupla[0].
PARIDAD, 1, 1 = one even-parity bit follows the data bits and is checked; 0 = no parity bit.

Ports:
Reloj  input  1  clock; all state changes on the rising edge.
Reiniciar  input  1  asynchronous, active-high reset.
Inicio  input  1  frame-start strobe; this cycle carries no data bit.
BitSerie  input  1  serial data bit; sampled only when BitValido=1.
BitValido  input  1  BitSerie qualifier; gaps of any length are allowed.
Tupla  output  ANCHO  last good word (feeds the register's data input).
Habilitar  output  1  one-cycle load pulse (feeds the register's enable).
Error  output  1  one-cycle pulse on parity mismatch or aborted frame.
Ocupado  output  1  high while a frame is in progress (any state except REPOSO).
TramasOk  output  8  count of good frames; wraps 255 -> 0.

Behaviour:
- Reset (asynchronous, active-high; may arrive at any time, including mid-frame):
  - Outputs: Tupla=0, Habilitar=0, Error=0, Ocupado=0, TramasOk=0.
  - Internals: shift register=0, bit counter=0, state=REPOSO.
- State machine: REPOSO, DESPLAZA, PARIDAD, EMITE.
- REPOSO:
  - BitValido is ignored.
  - Inicio=1: clear shift register and counter; go to DESPLAZA.
- DESPLAZA:
  - BitValido=1: shift BitSerie in per MSB_PRIMERO; counter+1.
  - When the ANCHO-th bit is sampled: go to PARIDAD if PARIDAD=1, otherwise go to EMITE.
  - BitValido=0: hold all state.
- PARIDAD:
  - On the next BitValido=1, compute the XOR of the 16 data bits and the parity bit.
  - XOR=0: go to EMITE.
  - XOR=1: pulse Error for one cycle; Tupla is left unchanged; go to REPOSO.
- EMITE (exactly one cycle):
  - Tupla <= assembled word; Habilitar=1; TramasOk+1 (modulo 256).
  - Next state REPOSO, or DESPLAZA (counter cleared) if Inicio=1 in this cycle.
- Latency: Tupla and Habilitar are registered. Habilitar is high in the cycle right after the edge that sampled the last bit (data bit or parity bit). Tupla is stable whenever Habilitar=1.
- Inicio=1 while in DESPLAZA or PARIDAD:
  - The current frame is aborted and Error pulses once.
  - Counter and shift register are cleared; state stays or becomes DESPLAZA.
  - A BitValido in that same cycle is ignored.
- Error and Habilitar are never high in the same cycle.
- Tupla only changes in EMITE or on reset.

Decomposition:
- Shared package holds the state encoding (2-bit constants REPOSO=0, DESPLAZA=1, PARIDAD=2, EMITE=3) and the default ANCHO=16.
- One natural sub-module: contador_bits (an up-counter with clear and enable, width $clog2(ANCHO+1)), reused for the bit count.
- The TramasOk counter is an inline 8-bit register.

Test Plan:
- Good frame: reset, then Inicio, then bits of 0xA5C3 MSB-first, then parity 0 -> one cycle after the parity bit, Habilitar=1 for one cycle, Tupla=0xA5C3, TramasOk=1, Error never asserted.
- Bad parity: same frame with parity bit 1 -> Error pulses once, Habilitar stays 0, Tupla stays 0x0000 after reset (or 0xA5C3 if run after the good frame), TramasOk unchanged.
- Abort: Inicio, 7 bits, then Inicio again, then 0x0001 with parity 1 -> Error pulses once at the second Inicio; exactly one Habilitar with Tupla=0x0001.
- Gaps and LSB-first: MSB_PRIMERO=0, frame 0x8000 with parity 1, BitValido low for 3 cycles between every bit -> Tupla=0x8000; Ocupado high from the cycle after Inicio until the cycle after EMITE.
- Reset mid-frame and wrap: assert Reiniciar after 9 bits -> all outputs 0 immediately, no Habilitar. Separately, send 256 good frames -> TramasOk returns to 0 and Habilitar has pulsed 256 times.
- Back-to-back frames: Inicio asserted in the EMITE cycle -> the next frame is accepted with no idle cycle; two Habilitar pulses with the correct words.
